bcd_serial_addsub: RTL

- Parametrised N-digit packed-BCD adder/subtractor.
- Processes one decimal digit per clock, least significant digit first, through a single internal 1-digit BCD add stage with +6 correction.
- Uses a start/busy/done handshake.
- Intended as the multi-digit arithmetic unit behind calculator/display datapaths; can be chained through cin/cout.

---
 rtl/bcd_serial_addsub.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Optional BCD_DIGIT_CHECK_EN adds an err output flagging non-BCD operands.
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic                  cin,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic [4*DIGITS-1:0]   s,
    output logic                  cout,
    output logic                  neg,
    output logic                  busy,
`ifdef BCD_DIGIT_CHECK_EN
    output logic                  err,
`endif
    output logic                  done
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic          carry;
    logic          sub_q;
    logic [IW-1:0] idx;
    logic [W-1:0]  b9;
    logic [4:0]    t;
    logic [3:0]    dig;
    logic          cnext;
    logic [W-1:0]  s_shift;
    logic          last;

`ifdef BCD_DIGIT_CHECK_EN
    logic bad;
    logic err_q;

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            bad = bad | (a[i*4 +: 4] > 4'd9) | (b[i*4 +: 4] > 4'd9);
        end
    end
`endif

    always_comb begin
        b9 = '0;
        for (int i = 0; i < DIGITS; i++) begin
            b9[i*4 +: 4] = 4'd9 - b[i*4 +: 4];
        end
    end

    // Single 1-digit BCD adder; operands shift right so digit i sits at [3:0]
    always_comb begin
        t     = {1'b0, opa[3:0]} + {1'b0, opb[3:0]} + {4'd0, carry};
        dig   = t[3:0];
        cnext = 1'b0;
        if (t > 5'd9) begin
            dig   = 4'(t + 5'd6);
            cnext = 1'b1;
        end
    end

    generate
        if (DIGITS == 1) begin : g_one
            assign s_shift = dig;
        end else begin : g_many
            assign s_shift = {dig, s[W-1:4]};
        end
    endgenerate

    assign last = (idx == IW'(DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            sub_q <= 1'b0;
            idx   <= '0;
            s     <= '0;
            cout  <= 1'b0;
            neg   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
            err   <= 1'b0;
            err_q <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        opa   <= a;
                        opb   <= sub ? b9 : b;
                        carry <= sub ? 1'b1 : cin;
                        sub_q <= sub;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
`ifdef BCD_DIGIT_CHECK_EN
                        err_q <= bad;
`endif
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    opa   <= opa >> 4;
                    opb   <= opb >> 4;
                    carry <= cnext;
                    idx   <= idx + 1'b1;
                    s     <= s_shift;
                    if (last) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cout  <= cnext;
                        neg   <= sub_q & ~cnext;
`ifdef BCD_DIGIT_CHECK_EN
                        err   <= err_q;
                        if (err_q) begin
                            s    <= '0;
                            cout <= 1'b0;
                            neg  <= 1'b0;
                        end
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
